// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - FPU opcode encodings and opcode classification helper.
package fpu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_CMP = 3'b100;

    function automatic logic is_arith(input logic [2:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: r = 1'b1;
            OP_CMP:                         r = 1'b0;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fpu_res_fifo.sv
// rtl/fpu_res_fifo.sv - Generic first-word-fall-through FIFO with pointers and occupancy count.
module fpu_res_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       pop_valid,
    input  logic                       pop_ready,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push, pop;

    // Acceptance looks only at the registered count, so a same-cycle pop never frees a slot.
    assign push_ready = (count_q != CW'(DEPTH));
    assign pop_valid  = (count_q != '0);
    assign push       = push_valid & push_ready;
    assign pop        = pop_valid & pop_ready;
    assign pop_data   = pop_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fpu_result_stage.sv
// rtl/fpu_result_stage.sv - FPU result buffer with flag qualification and sticky exception status.
// Optional FPU_EXC_COUNT_EN adds saturating overflow/underflow event counters.
module fpu_result_stage
    import fpu_pkg::*;
#(
    parameter int NEXP  = 8,
    parameter int NSIG  = 23,
`ifdef FPU_EXC_COUNT_EN
    parameter int CNT_W = 16,
`endif
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NEXP+NSIG:0]       in_p,
    input  logic [2:0]               in_opcode,
    input  logic                     in_ovf,
    input  logic                     in_unf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NEXP+NSIG:0]       out_p,
    output logic [2:0]               out_opcode,
    output logic                     out_ovf,
    output logic                     out_unf,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     sticky_clr,
    output logic                     sticky_ovf,
`ifdef FPU_EXC_COUNT_EN
    output logic [CNT_W-1:0]         ovf_cnt,
    output logic [CNT_W-1:0]         unf_cnt,
`endif
    output logic                     sticky_unf
);

    localparam int W  = NEXP + NSIG + 1;
    localparam int EW = W + 5;

    logic          push;
    logic          st_ovf, st_unf;
    logic [EW-1:0] wr_entry, rd_entry;
    logic          sticky_ovf_q, sticky_ovf_d;
    logic          sticky_unf_q, sticky_unf_d;

    // Compare and reserved opcodes cannot raise exceptions; their flags are dropped at capture.
    assign st_ovf   = is_arith(in_opcode) & in_ovf;
    assign st_unf   = is_arith(in_opcode) & in_unf;
    assign push     = in_valid & in_ready;
    assign wr_entry = {in_opcode, st_ovf, st_unf, in_p};

    fpu_res_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  (wr_entry),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (rd_entry),
        .count      (count)
    );

    assign {out_opcode, out_ovf, out_unf, out_p} = rd_entry;

    // A setting push overrides a simultaneous clear.
    always_comb begin
        sticky_ovf_d = (sticky_ovf_q & ~sticky_clr) | (push & st_ovf);
        sticky_unf_d = (sticky_unf_q & ~sticky_clr) | (push & st_unf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_ovf_q <= 1'b0;
            sticky_unf_q <= 1'b0;
        end else begin
            sticky_ovf_q <= sticky_ovf_d;
            sticky_unf_q <= sticky_unf_d;
        end
    end

    assign sticky_ovf = sticky_ovf_q;
    assign sticky_unf = sticky_unf_q;

`ifdef FPU_EXC_COUNT_EN
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0] unf_cnt_q, unf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        unf_cnt_d = unf_cnt_q;
        if (sticky_clr) begin
            ovf_cnt_d = (push & st_ovf) ? CNT_W'(1) : '0;
            unf_cnt_d = (push & st_unf) ? CNT_W'(1) : '0;
        end else begin
            if (push & st_ovf & ~(&ovf_cnt_q)) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
            if (push & st_unf & ~(&unf_cnt_q)) unf_cnt_d = unf_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= '0;
            unf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            unf_cnt_q <= unf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
    assign unf_cnt = unf_cnt_q;
`endif

endmodule

// File: tb/tb_fpu_result_stage.sv
// tb/tb_fpu_result_stage.sv - Directed self-checking bench for fpu_result_stage.
module tb_fpu_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_p;
    logic [2:0]  in_opcode;
    logic        in_ovf, in_unf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_p;
    logic [2:0]  out_opcode;
    logic        out_ovf, out_unf;
    logic [2:0]  count;
    logic        sticky_clr;
    logic        sticky_ovf, sticky_unf;
`ifdef FPU_EXC_COUNT_EN
    logic [1:0]  ovf_cnt, unf_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fpu_result_stage #(
        .NEXP  (8),
        .NSIG  (23),
`ifdef FPU_EXC_COUNT_EN
        .CNT_W (2),
`endif
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_p       (in_p),
        .in_opcode  (in_opcode),
        .in_ovf     (in_ovf),
        .in_unf     (in_unf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_p      (out_p),
        .out_opcode (out_opcode),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf),
        .count      (count),
        .sticky_clr (sticky_clr),
        .sticky_ovf (sticky_ovf),
`ifdef FPU_EXC_COUNT_EN
        .ovf_cnt    (ovf_cnt),
        .unf_cnt    (unf_cnt),
`endif
        .sticky_unf (sticky_unf)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] p, input logic [2:0] op,
                         input logic ovf, input logic unf);
        in_valid  = v;
        in_p      = p;
        in_opcode = op;
        in_ovf    = ovf;
        in_unf    = unf;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        sticky_clr = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_count", count, 0);
        check_eq("rst_out_p", out_p, 0);
        check_eq("rst_sticky", {sticky_ovf, sticky_unf}, 0);

        // single add result falls through after one edge
        drive(1'b1, 32'h3F800000, 3'b000, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        check_eq("t1_out_valid", out_valid, 1);
        check_eq("t1_out_p", out_p, 32'h3F800000);
        check_eq("t1_count", count, 1);
        check_eq("t1_sticky_ovf", sticky_ovf, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("t1_drained", count, 0);

        // fill to four entries
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h40000000 + i, i[2:0], 1'b0, 1'b0);
            step();
        end
        check_eq("t2_in_ready_full", in_ready, 0);
        check_eq("t2_count_full", count, 4);
        drive(1'b1, 32'hDEADBEEF, 3'b000, 1'b0, 1'b0);
        step();
        check_eq("t2_fifth_ignored", count, 4);
        check_eq("t2_head_stable", out_p, 32'h40000000);

        // full with push and pop requested: pop only
        out_ready = 1'b1;
        step();
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        out_ready = 1'b0;
        check_eq("t3_count", count, 3);
        check_eq("t3_in_ready", in_ready, 1);

        for (int i = 1; i < 4; i++) begin
            check_eq("t2_order_p", out_p, 32'h40000000 + i);
            check_eq("t2_order_op", out_opcode, i);
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        check_eq("t2_empty", out_valid, 0);

        // overflow on mul sets sticky; compare drops flags
        drive(1'b1, 32'h7F800000, 3'b010, 1'b1, 1'b0);
        step();
        check_eq("t4_sticky_ovf", sticky_ovf, 1);
        check_eq("t4_mul_ovf", out_ovf, 1);
        drive(1'b1, 32'h00000001, 3'b100, 1'b1, 1'b1);
        out_ready = 1'b1;
        step();
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        out_ready = 1'b0;
        check_eq("t4_cmp_op", out_opcode, 3'b100);
        check_eq("t4_cmp_p", out_p, 32'h00000001);
        check_eq("t4_cmp_flags", {out_ovf, out_unf}, 0);
        check_eq("t4_sticky_unf", sticky_unf, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // clear, then clear coinciding with a setting push
        sticky_clr = 1'b1;
        step();
        check_eq("t5_cleared", {sticky_ovf, sticky_unf}, 0);
        drive(1'b1, 32'h00000002, 3'b011, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        sticky_clr = 1'b0;
        check_eq("t5_set_wins", sticky_unf, 1);
        check_eq("t5_ovf_clear", sticky_ovf, 0);
        check_eq("t5_div_unf", out_unf, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

`ifdef FPU_EXC_COUNT_EN
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check_eq("t6_cnt_clr", {ovf_cnt, unf_cnt}, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h7F800000, 3'b010, 1'b1, 1'b0);
            step();
        end
        check_eq("t6_ovf_sat", ovf_cnt, 3);
        check_eq("t6_unf_zero", unf_cnt, 0);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        check_eq("t6_clr_and_inc", ovf_cnt, 1);
        step();
        out_ready = 1'b0;
        check_eq("t6_drained", count, 0);
`endif

        // reset in the middle of a drain
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h12340000 + i, 3'b000, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        check_eq("t6_pre_rst_count", count, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        check_eq("t6_rst_count", count, 0);
        check_eq("t6_rst_valid", out_valid, 0);
        check_eq("t6_rst_out_p", out_p, 0);
        check_eq("t6_rst_sticky", {sticky_ovf, sticky_unf}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
